// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and its helpers.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_FAULT   = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_X0              = 5'd0;
    localparam int         DEFAULT_MEM_TIMEOUT = 255;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Pure combinational load-use compare: a load in EX whose destination is read by the ID instruction.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic       ex_isValid_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_mem_read_i,
    output logic       load_use_o
);

    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    // x0 never carries a dependency, so a load targeting it cannot cause a stall.
    assign rd_live    = ex_isValid_i && ex_mem_read_i && (ex_rd_i != REG_X0);
    assign rs1_hit    = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit    = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    assign load_use_o = rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze with watchdog, branch redirect, load-use bubble.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_isValid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             mem_isValid,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    localparam logic [TO_W-1:0]  WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    hz_state_e        state_q;
    logic [TO_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic in_fault;
    logic freeze;
    logic redirect;
    logic load_use;

    // Bit 1 set covers both FAULT and the unused encoding 2'd3.
    assign in_fault = state_q[1];
    assign freeze   = mem_req && !mem_ready;
    assign redirect = ex_isValid && ex_branch_taken;

    hazard_detect u_hazard_detect (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs1_i (id_uses_rs1),
        .id_uses_rs2_i (id_uses_rs2),
        .ex_isValid_i  (ex_isValid),
        .ex_rd_i       (ex_rd),
        .ex_mem_read_i (ex_mem_read),
        .load_use_o    (load_use)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (freeze) begin
                        state_q    <= ST_MEMWAIT;
                        wait_cnt_q <= '0;
                    end
                end
                ST_MEMWAIT: begin
                    if (mem_ready) begin
                        state_q <= ST_RUN;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q <= ST_FAULT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: state_q <= state_q;
            endcase

            if (!in_fault && !pc_en && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        mem_isValid = 1'b1;
        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            mem_isValid = 1'b0;
        end else if (in_fault || freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            mem_isValid = 1'b0;
        end else if (redirect) begin
            // The ID instruction is squashed, so any load-use it would cause is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign mem_fault = !reset && in_fault;
    assign stall_cnt = reset ? '0 : stall_cnt_q;
    assign state     = reset ? ST_RUN : state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: table of single-cycle output vectors plus hand sequences for wait, timeout, reset and saturation.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_isValid, ex_mem_read, ex_branch_taken;
    logic       mem_req, mem_ready;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, mem_isValid, mem_fault;
    logic [2:0] stall_cnt;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, mem_isValid}
    localparam logic [6:0] O_NORMAL = 7'b1101011;
    localparam logic [6:0] O_REDIR  = 7'b1111111;
    localparam logic [6:0] O_LU     = 7'b0000111;
    localparam logic [6:0] M_LU     = 7'b1100111;
    localparam logic [6:0] O_HOLD   = 7'b0000000;
    localparam logic [6:0] O_RESET  = 7'b0010100;
    localparam logic [6:0] M_ALL    = 7'b1111111;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .TO_W        (8),
        .CNT_W       (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_isValid      (ex_isValid),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .mem_isValid     (mem_isValid),
        .mem_fault       (mem_fault),
        .stall_cnt       (stall_cnt),
        .state           (state)
    );

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       exv;
        logic [4:0] rd;
        logic       mr;
        logic       bt;
        logic       mreq;
        logic       mrdy;
        logic [6:0] exp;
        logic [6:0] mask;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [6:0] outs();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, mem_isValid};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic check_outs(input string name, input logic [6:0] exp, input logic [6:0] mask);
        check(name, 32'(outs() & mask), 32'(exp & mask));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_isValid = 1'b0; ex_rd = 5'd0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
    endtask

    task automatic load_use_inputs();
        ex_isValid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{"idle",          5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, O_NORMAL, M_ALL};
        vecs[1]  = '{"lu_rs1",        5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_LU,     M_LU};
        vecs[2]  = '{"lu_rs2",        5'd1,  5'd5,  1'b0, 1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_LU,     M_LU};
        vecs[3]  = '{"rs1_unused",    5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_NORMAL, M_ALL};
        vecs[4]  = '{"load_x0",       5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, O_NORMAL, M_ALL};
        vecs[5]  = '{"ex_invalid",    5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_NORMAL, M_ALL};
        vecs[6]  = '{"not_load",      5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, O_NORMAL, M_ALL};
        vecs[7]  = '{"branch_lu",     5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, O_REDIR,  M_ALL};
        vecs[8]  = '{"branch_invld",  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, O_NORMAL, M_ALL};
        vecs[9]  = '{"mem_ack_lu",    5'd5,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b1, 1'b1, O_LU,     M_LU};
        vecs[10] = '{"lu_r31",        5'd30, 5'd31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, O_LU,     M_LU};
        vecs[11] = '{"no_match",      5'd5,  5'd7,  1'b1, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, O_NORMAL, M_ALL};

        // Reset-time behaviour
        reset = 1'b1;
        idle();
        step();
        check_outs("reset_outs", O_RESET, M_ALL);
        check("reset_state", 32'(state), 32'd0);
        check("reset_cnt", 32'(stall_cnt), 32'd0);
        check("reset_fault", 32'(mem_fault), 32'd0);
        reset = 1'b0;

        // Single-cycle output table, all from RUN
        for (int i = 0; i < 12; i++) begin
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_isValid = vecs[i].exv; ex_rd = vecs[i].rd;
            ex_mem_read = vecs[i].mr; ex_branch_taken = vecs[i].bt;
            mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
            #2;
            check_outs(vecs[i].name, vecs[i].exp, vecs[i].mask);
            step();
        end

        // Load-use: one bubble, counter 0 -> 1
        do_reset();
        load_use_inputs();
        #2;
        check_outs("lu_seq_stall", O_LU, M_LU);
        check("lu_seq_cnt0", 32'(stall_cnt), 32'd0);
        step();
        idle();
        ex_isValid = 1'b1;
        #2;
        check_outs("lu_seq_release", O_NORMAL, M_ALL);
        check("lu_seq_cnt1", 32'(stall_cnt), 32'd1);

        // Memory wait for three cycles, then release
        do_reset();
        mem_req = 1'b1;
        #2;
        check_outs("mw_run_freeze", O_HOLD, M_ALL);
        check("mw_run_state", 32'(state), 32'd0);
        for (int c = 1; c <= 2; c++) begin
            step();
            check("mw_state", 32'(state), 32'd1);
            check_outs("mw_freeze", O_HOLD, M_ALL);
            check("mw_cnt", 32'(stall_cnt), 32'(c));
        end
        step();
        mem_ready = 1'b1;
        #2;
        check("mw_cnt3", 32'(stall_cnt), 32'd3);
        check_outs("mw_ready_adv", O_NORMAL, M_ALL);
        step();
        mem_req = 1'b0; mem_ready = 1'b0;
        #2;
        check("mw_back_run", 32'(state), 32'd0);
        check("mw_cnt_hold", 32'(stall_cnt), 32'd3);

        // Watchdog: RUN freeze cycle + 4 MEMWAIT cycles, then FAULT
        do_reset();
        mem_req = 1'b1;
        step();
        for (int c = 0; c < 4; c++) begin
            check("to_memwait", 32'(state), 32'd1);
            step();
        end
        check("to_fault_state", 32'(state), 32'd2);
        check("to_fault_flag", 32'(mem_fault), 32'd1);
        check_outs("to_fault_outs", O_HOLD, M_ALL);
        check("to_cnt", 32'(stall_cnt), 32'd5);
        mem_ready = 1'b1;
        ex_isValid = 1'b1; ex_branch_taken = 1'b1;
        step();
        step();
        check("to_sticky_state", 32'(state), 32'd2);
        check("to_sticky_flag", 32'(mem_fault), 32'd1);
        check_outs("to_sticky_outs", O_HOLD, M_ALL);
        check("to_cnt_frozen", 32'(stall_cnt), 32'd5);
        reset = 1'b1;
        #2;
        check_outs("to_rst_outs", O_RESET, M_ALL);
        check("to_rst_fault", 32'(mem_fault), 32'd0);
        step();
        reset = 1'b0;
        idle();
        #2;
        check("to_rst_state", 32'(state), 32'd0);
        check("to_rst_cnt", 32'(stall_cnt), 32'd0);
        check("to_rst_flag", 32'(mem_fault), 32'd0);

        // Reset while in MEMWAIT
        mem_req = 1'b1;
        step();
        step();
        check("rmw_in_wait", 32'(state), 32'd1);
        reset = 1'b1;
        #2;
        check_outs("rmw_rst_outs", O_RESET, M_ALL);
        step();
        reset = 1'b0;
        idle();
        #2;
        check("rmw_state", 32'(state), 32'd0);
        check("rmw_cnt", 32'(stall_cnt), 32'd0);
        // A fresh wait must again last 4 MEMWAIT cycles if the wait counter was cleared
        mem_req = 1'b1;
        step();
        for (int c = 0; c < 4; c++) step();
        check("rmw_timeout_again", 32'(state), 32'd2);

        // Counter saturation at 2^3-1
        do_reset();
        load_use_inputs();
        for (int c = 0; c < 7; c++) step();
        check("sat_cnt7", 32'(stall_cnt), 32'd7);
        step();
        step();
        check("sat_hold", 32'(stall_cnt), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
